// File: rtl/rail_sequencer.sv
// rail_sequencer: N-rail power sequencer. Rails come up in index order, each gated on a debounced
// power-good, and go down in reverse order on disable or fault, followed by a restart hold-off.
// Ports: sysclk, reset (async, active-high), enable, rail_good[N] (async raw)
//        -> rail_en[N], seq_on, fault, fault_rail[3], state[3], step[3].
module rail_sequencer #(
  parameter int NUM_RAILS      = 4,
  parameter int TICK_DIV       = 8192,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int TIMEOUT_TICKS  = 15,
  parameter int HOLDOFF_TICKS  = 15
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_RAILS-1:0] rail_good,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 seq_on,
  output logic                 fault,
  output logic [2:0]           fault_rail,
  output logic [2:0]           state,
  output logic [2:0]           step
);

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_UP   = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TMAX = (TIMEOUT_TICKS > HOLDOFF_TICKS) ?
                        TIMEOUT_TICKS : HOLDOFF_TICKS;
  localparam int TW = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam logic [2:0] LAST = 3'(NUM_RAILS - 1);

  logic [DW-1:0]        div_q, div_d;
  logic                 tick;
  logic [NUM_RAILS-1:0] sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q [NUM_RAILS];
  logic [CW-1:0]        cnt_d [NUM_RAILS];
  logic [NUM_RAILS-1:0] rail_ok;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 timeout;
  logic [2:0]           state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 seq_on_q, seq_on_d;
  logic                 fault_q, fault_d;
  logic [2:0]           fault_rail_q, fault_rail_d;

  logic                 cur_ok;
  logic                 bad_up, bad_all;
  logic [2:0]           bad_up_idx, bad_all_idx;
  logic                 fault_set;
  logic [2:0]           fault_idx;

  always_comb begin
    tick  = (div_q == DW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_RAILS; i++) begin
      rail_ok[i] = (cnt_q[i] == CW'(DEBOUNCE_TICKS));
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        if (!sync2_q[i])
          cnt_d[i] = '0;
        else if (!rail_ok[i])
          cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Scan from the top so the lowest failing rail is the one recorded.
  always_comb begin
    cur_ok      = 1'b0;
    bad_up      = 1'b0;
    bad_all     = 1'b0;
    bad_up_idx  = 3'd0;
    bad_all_idx = 3'd0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (3'(j) == step_q)
        cur_ok = rail_ok[j];
      if (!rail_ok[j]) begin
        bad_all     = 1'b1;
        bad_all_idx = 3'(j);
        if (3'(j) < step_q) begin
          bad_up     = 1'b1;
          bad_up_idx = 3'(j);
        end
      end
    end
  end

  assign timeout = (timer_q == TW'(TIMEOUT_TICKS));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    fault_set    = 1'b0;
    fault_idx    = 3'd0;
    if (tick) begin
      case (state_q)
        S_OFF: begin
          if (!enable) begin
            fault_d      = 1'b0;
            fault_rail_d = 3'd0;
          end else if (!fault_q) begin
            state_d = S_UP;
            step_d  = 3'd0;
          end
        end
        S_UP: begin
          if (!enable) begin
            state_d = S_DOWN;
          end else if (bad_up) begin
            fault_set = 1'b1;
            fault_idx = bad_up_idx;
            state_d   = S_DOWN;
          end else if (cur_ok) begin
            if (step_q == LAST) begin
              state_d = S_ON;
              step_d  = 3'd0;
            end else begin
              step_d = step_q + 3'd1;
            end
          end else if (timeout) begin
            fault_set = 1'b1;
            fault_idx = step_q;
            state_d   = S_DOWN;
          end
        end
        S_ON: begin
          if (!enable) begin
            state_d = S_DOWN;
            step_d  = LAST;
          end else if (bad_all) begin
            fault_set = 1'b1;
            fault_idx = bad_all_idx;
            state_d   = S_DOWN;
            step_d    = LAST;
          end
        end
        S_DOWN: begin
          if (!cur_ok || timeout) begin
            fault_set = timeout;
            fault_idx = step_q;
            if (step_q == 3'd0)
              state_d = S_HOLD;
            else
              step_d = step_q - 3'd1;
          end
        end
        S_HOLD: begin
          if (timer_q == TW'(HOLDOFF_TICKS))
            state_d = S_OFF;
        end
        default: begin
          state_d = S_OFF;
          step_d  = 3'd0;
        end
      endcase
    end
    // Only the first fault is recorded until OFF clears it.
    if (fault_set && !fault_q) begin
      fault_d      = 1'b1;
      fault_rail_d = fault_idx;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (tick) begin
      if (state_d != state_q || step_d != step_q)
        timer_d = '0;
      else if (timer_q != TW'(TMAX))
        timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RAILS; i++) begin
      rail_en_d[i] = (state_d == S_ON) ||
                     (state_d == S_UP && 3'(i) <= step_d) ||
                     (state_d == S_DOWN && 3'(i) < step_d);
    end
    seq_on_d = (state_d == S_ON);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      timer_q      <= '0;
      state_q      <= S_OFF;
      step_q       <= 3'd0;
      rail_en_q    <= '0;
      seq_on_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= 3'd0;
      for (int i = 0; i < NUM_RAILS; i++)
        cnt_q[i] <= '0;
    end else begin
      div_q        <= div_d;
      sync1_q      <= rail_good;
      sync2_q      <= sync1_q;
      timer_q      <= timer_d;
      state_q      <= state_d;
      step_q       <= step_d;
      rail_en_q    <= rail_en_d;
      seq_on_q     <= seq_on_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      for (int i = 0; i < NUM_RAILS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign rail_en    = rail_en_q;
  assign seq_on     = seq_on_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign state      = state_q;
  assign step       = step_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// tb_rail_sequencer: directed bench for rail_sequencer with 3 rails, tick every 4 clocks,
// debounce 2, timeout 6, hold-off 3. A simple regulator model echoes rail_en masked per rail.
module tb_rail_sequencer;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_UP   = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic       sysclk;
  logic       reset;
  logic       enable;
  logic [2:0] rail_good;
  logic [2:0] rail_en;
  logic       seq_on;
  logic       fault;
  logic [2:0] fault_rail;
  logic [2:0] state;
  logic [2:0] step;

  logic [2:0] good_mask;
  int         total;
  int         bad;

  rail_sequencer #(
    .NUM_RAILS(3),
    .TICK_DIV(4),
    .DEBOUNCE_TICKS(2),
    .TIMEOUT_TICKS(6),
    .HOLDOFF_TICKS(3)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .enable(enable),
    .rail_good(rail_good),
    .rail_en(rail_en),
    .seq_on(seq_on),
    .fault(fault),
    .fault_rail(fault_rail),
    .state(state),
    .step(step)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      rail_good = rail_en & good_mask;
    end
  endtask

  // Returns the number of falling edges until state/step match, or -1.
  task automatic run_until(input logic [2:0] st, input logic [2:0] sp,
                           input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge sysclk);
      rail_good = rail_en & good_mask;
      if (state == st && step == sp) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    total++; if (state !== S_OFF) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (step !== 3'd0) begin bad++; $display("FAIL rst_step got=%0d want=0", step); end
    total++; if (rail_en !== 3'b000) begin bad++; $display("FAIL rst_en got=%b want=000", rail_en); end
    total++; if (seq_on !== 1'b0) begin bad++; $display("FAIL rst_seq_on got=%b want=0", seq_on); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", fault); end
    total++; if (fault_rail !== 3'd0) begin bad++; $display("FAIL rst_frail got=%0d want=0", fault_rail); end
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_power_up;
    int n;
    enable = 1'b1;
    good_mask = 3'b111;
    run_until(S_UP, 3'd0, 8, n);
    total++; if (n !== 4) begin bad++; $display("FAIL up0_lat got=%0d want=4", n); end
    total++; if (rail_en !== 3'b001) begin bad++; $display("FAIL up0_en got=%b want=001", rail_en); end
    run_until(S_UP, 3'd1, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL up1_lat got=%0d want=12", n); end
    total++; if (rail_en !== 3'b011) begin bad++; $display("FAIL up1_en got=%b want=011", rail_en); end
    run_until(S_UP, 3'd2, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL up2_lat got=%0d want=12", n); end
    total++; if (rail_en !== 3'b111) begin bad++; $display("FAIL up2_en got=%b want=111", rail_en); end
    total++; if (seq_on !== 1'b0) begin bad++; $display("FAIL up2_seq_on got=%b want=0", seq_on); end
    run_until(S_ON, 3'd0, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL on_lat got=%0d want=12", n); end
    total++; if (seq_on !== 1'b1) begin bad++; $display("FAIL on_seq_on got=%b want=1", seq_on); end
    total++; if (rail_en !== 3'b111) begin bad++; $display("FAIL on_en got=%b want=111", rail_en); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL on_fault got=%b want=0", fault); end
  endtask

  task automatic test_disable;
    int n;
    enable = 1'b0;
    run_until(S_DOWN, 3'd2, 8, n);
    total++; if (n !== 4) begin bad++; $display("FAIL dn2_lat got=%0d want=4", n); end
    total++; if (rail_en !== 3'b011) begin bad++; $display("FAIL dn2_en got=%b want=011", rail_en); end
    total++; if (seq_on !== 1'b0) begin bad++; $display("FAIL dn2_seq_on got=%b want=0", seq_on); end
    run_until(S_DOWN, 3'd1, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL dn1_lat got=%0d want=8", n); end
    total++; if (rail_en !== 3'b001) begin bad++; $display("FAIL dn1_en got=%b want=001", rail_en); end
    run_until(S_DOWN, 3'd0, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL dn0_lat got=%0d want=8", n); end
    total++; if (rail_en !== 3'b000) begin bad++; $display("FAIL dn0_en got=%b want=000", rail_en); end
    run_until(S_HOLD, 3'd0, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL hold_lat got=%0d want=8", n); end
    run_until(S_OFF, 3'd0, 40, n);
    total++; if (n !== 16) begin bad++; $display("FAIL off_lat got=%0d want=16", n); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL dis_fault got=%b want=0", fault); end
  endtask

  task automatic test_timeout;
    int n;
    good_mask = 3'b101;
    enable = 1'b1;
    run_until(S_UP, 3'd0, 8, n);
    total++; if (n < 1) begin bad++; $display("FAIL to_up0 got=%0d want=1..8", n); end
    run_until(S_UP, 3'd1, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL to_up1_lat got=%0d want=12", n); end
    run_until(S_DOWN, 3'd1, 60, n);
    total++; if (n !== 28) begin bad++; $display("FAIL to_lat got=%0d want=28", n); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", fault); end
    total++; if (fault_rail !== 3'd1) begin bad++; $display("FAIL to_frail got=%0d want=1", fault_rail); end
    total++; if (rail_en !== 3'b001) begin bad++; $display("FAIL to_dn1_en got=%b want=001", rail_en); end
    run_until(S_DOWN, 3'd0, 16, n);
    total++; if (n !== 4) begin bad++; $display("FAIL to_dn0_lat got=%0d want=4", n); end
    total++; if (rail_en !== 3'b000) begin bad++; $display("FAIL to_dn0_en got=%b want=000", rail_en); end
    run_until(S_HOLD, 3'd0, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL to_hold_lat got=%0d want=8", n); end
    run_until(S_OFF, 3'd0, 40, n);
    total++; if (n !== 16) begin bad++; $display("FAIL to_off_lat got=%0d want=16", n); end
    cyc(12);
    total++; if (state !== S_OFF) begin bad++; $display("FAIL to_lock_state got=%0d want=0", state); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_lock_fault got=%b want=1", fault); end
    total++; if (fault_rail !== 3'd1) begin bad++; $display("FAIL to_lock_frail got=%0d want=1", fault_rail); end
    enable = 1'b0;
    cyc(4);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL to_clr_fault got=%b want=0", fault); end
    total++; if (fault_rail !== 3'd0) begin bad++; $display("FAIL to_clr_frail got=%0d want=0", fault_rail); end
  endtask

  task automatic test_glitch;
    int n;
    good_mask = 3'b110;
    enable = 1'b1;
    run_until(S_UP, 3'd0, 8, n);
    total++; if (n < 1) begin bad++; $display("FAIL gl_up0 got=%0d want=1..8", n); end
    good_mask[0] = 1'b1;
    rail_good = rail_en & good_mask;
    cyc(4);
    good_mask[0] = 1'b0;
    rail_good = rail_en & good_mask;
    cyc(8);
    total++; if (state !== S_UP) begin bad++; $display("FAIL gl_hold_state got=%0d want=1", state); end
    total++; if (step !== 3'd0) begin bad++; $display("FAIL gl_hold_step got=%0d want=0", step); end
    good_mask[0] = 1'b1;
    rail_good = rail_en & good_mask;
    run_until(S_UP, 3'd1, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL gl_adv_lat got=%0d want=12", n); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL gl_fault got=%b want=0", fault); end
  endtask

  task automatic test_brownout;
    int n;
    good_mask = 3'b111;
    run_until(S_ON, 3'd0, 64, n);
    total++; if (seq_on !== 1'b1) begin bad++; $display("FAIL bo_on got=%b want=1", seq_on); end
    good_mask = 3'b101;
    rail_good = rail_en & good_mask;
    cyc(4);
    good_mask = 3'b111;
    rail_good = rail_en & good_mask;
    run_until(S_DOWN, 3'd2, 16, n);
    total++; if (n !== 4) begin bad++; $display("FAIL bo_lat got=%0d want=4", n); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL bo_fault got=%b want=1", fault); end
    total++; if (fault_rail !== 3'd1) begin bad++; $display("FAIL bo_frail got=%0d want=1", fault_rail); end
    total++; if (rail_en !== 3'b011) begin bad++; $display("FAIL bo_dn2_en got=%b want=011", rail_en); end
    total++; if (seq_on !== 1'b0) begin bad++; $display("FAIL bo_seq_on got=%b want=0", seq_on); end
    run_until(S_DOWN, 3'd1, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL bo_dn1_lat got=%0d want=8", n); end
    total++; if (rail_en !== 3'b001) begin bad++; $display("FAIL bo_dn1_en got=%b want=001", rail_en); end
    run_until(S_DOWN, 3'd0, 40, n);
    total++; if (n !== 8) begin bad++; $display("FAIL bo_dn0_lat got=%0d want=8", n); end
    total++; if (rail_en !== 3'b000) begin bad++; $display("FAIL bo_dn0_en got=%b want=000", rail_en); end
    run_until(S_OFF, 3'd0, 60, n);
    total++; if (n !== 24) begin bad++; $display("FAIL bo_off_lat got=%0d want=24", n); end
    total++; if (fault_rail !== 3'd1) begin bad++; $display("FAIL bo_frail_end got=%0d want=1", fault_rail); end
  endtask

  task automatic test_reset_mid_up;
    int n;
    enable = 1'b0;
    cyc(4);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rm_clr got=%b want=0", fault); end
    enable = 1'b1;
    good_mask = 3'b111;
    run_until(S_UP, 3'd0, 8, n);
    run_until(S_UP, 3'd1, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL rm_up1_lat got=%0d want=12", n); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (rail_en !== 3'b000) begin bad++; $display("FAIL rm_async_en got=%b want=000", rail_en); end
    total++; if (state !== S_OFF) begin bad++; $display("FAIL rm_async_state got=%0d want=0", state); end
    total++; if (step !== 3'd0) begin bad++; $display("FAIL rm_async_step got=%0d want=0", step); end
    cyc(2);
    reset = 1'b0;
    run_until(S_UP, 3'd0, 8, n);
    total++; if (n !== 4) begin bad++; $display("FAIL rm_up0_lat got=%0d want=4", n); end
    run_until(S_UP, 3'd1, 40, n);
    total++; if (n !== 12) begin bad++; $display("FAIL rm_up1_again got=%0d want=12", n); end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    rail_good = 3'b000;
    good_mask = 3'b000;
    total = 0;
    bad = 0;
    test_reset();
    test_power_up();
    test_disable();
    test_timeout();
    test_glitch();
    test_brownout();
    test_reset_mid_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
